vga_scan_controller: RTL and testbench

VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_scan_controller_if.sv | 30 +++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_scan_controller.sv | 142 ++++++++++++++
 tb/tb_vga_scan_controller.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 scan timing constants and shared scan-control types.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;

    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;
    localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    localparam int c_FRAME_W      = 640;
    localparam int c_FRAME_H      = 480;
    localparam int c_FRAME_CYCLES = c_H_TOTAL * c_V_TOTAL;
    // Digit sprites live directly above the framebuffer in the shared memory map
    localparam int c_SPRITE_BASE  = c_FRAME_W * c_FRAME_H;

    localparam int c_ADDR_W  = 19;
    localparam int c_COLOR_W = 24;

    typedef struct packed {
        logic visible;
        logic sync_h;
        logic sync_v;
    } scan_ctl_t;

    function automatic logic [c_ADDR_W-1:0] f_pixel_addr(input int x, input int y);
        return c_ADDR_W'(y * c_FRAME_W + x);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_controller_if
// Brief    : Framebuffer fetch and VGA pin bundle of the scan controller.
// Revision : 1.0
// ============================================================================
interface vga_scan_controller_if;
    import vga_timing_pkg::*;

    logic [c_ADDR_W-1:0]  curAddress;
    logic [c_COLOR_W-1:0] colorIn;
    logic [7:0]           vga_r;
    logic [7:0]           vga_g;
    logic [7:0]           vga_b;
    logic                 vga_hs;
    logic                 vga_vs;
    logic                 vga_blank_n;
    logic                 frame_start;

    modport master (
        output curAddress, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
        input  colorIn
    );

    modport slave (
        input  curAddress, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
        output colorIn
    );
endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Brief    : Parameterised width/depth shift register with async reset value.
// Revision : 1.0
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire             clk,
    input  wire             rst,
    input  wire [WIDTH-1:0] i_d,
    output wire [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_controller
// Brief    : VGA raster scanner: framebuffer address fetch, latency-matched
//            sync/blank pipeline and registered DAC outputs.
// Revision : 1.0
// ============================================================================
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int READ_LATENCY = 2,   // legal 1..4
    parameter int H_VISIBLE    = c_H_VISIBLE,
    parameter int H_FRONT      = c_H_FRONT,
    parameter int H_SYNC       = c_H_SYNC,
    parameter int H_BACK       = c_H_BACK,
    parameter int V_VISIBLE    = c_V_VISIBLE,
    parameter int V_FRONT      = c_V_FRONT,
    parameter int V_SYNC       = c_V_SYNC,
    parameter int V_BACK       = c_V_BACK
) (
    input  wire                   clock,
    input  wire                   reset,
    vga_scan_controller_if.master bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HCW      = $clog2(H_TOTAL);
    localparam int VCW      = $clog2(V_TOTAL);
    localparam int PIX_LAST = H_VISIBLE * V_VISIBLE - 1;

    logic [HCW-1:0]      r_hcnt;
    logic [HCW-1:0]      w_hcnt_nxt;
    logic [VCW-1:0]      r_vcnt;
    logic [VCW-1:0]      w_vcnt_nxt;
    logic                w_vis;
    logic                w_vis_nxt;
    logic [c_ADDR_W-1:0] r_base;
    logic [c_ADDR_W-1:0] w_base_nxt;
    logic [c_ADDR_W-1:0] r_addr;
    logic                r_frame_start;
    scan_ctl_t           w_ctl;
    scan_ctl_t           w_ctl_dly;
    logic [7:0]          r_r;
    logic [7:0]          r_g;
    logic [7:0]          r_b;
    logic                r_hs;
    logic                r_vs;
    logic                r_blank_n;

    function automatic logic f_visible(input logic [HCW-1:0] h, input logic [VCW-1:0] v);
        return (h < HCW'(H_VISIBLE)) && (v < VCW'(V_VISIBLE));
    endfunction

    always_comb begin
        w_hcnt_nxt = r_hcnt + 1'b1;
        w_vcnt_nxt = r_vcnt;
        if (r_hcnt == HCW'(H_TOTAL - 1)) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = (r_vcnt == VCW'(V_TOTAL - 1)) ? '0 : r_vcnt + 1'b1;
        end
    end

    assign w_vis     = f_visible(r_hcnt, r_vcnt);
    assign w_vis_nxt = f_visible(w_hcnt_nxt, w_vcnt_nxt);

    // r_base is the address the next visible fetch will use; it only moves on
    // visible cycles, so lines concatenate without a multiplier.
    always_comb begin
        w_base_nxt = r_base;
        if (w_vis) begin
            w_base_nxt = (r_base == c_ADDR_W'(PIX_LAST)) ? '0 : r_base + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_base        <= '0;
            r_addr        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_base        <= w_base_nxt;
            r_addr        <= w_vis_nxt ? w_base_nxt : '0;
            r_frame_start <= (w_hcnt_nxt == '0) && (w_vcnt_nxt == VCW'(V_VISIBLE));
        end
    end

    assign w_ctl.visible = w_vis;
    assign w_ctl.sync_h  = (r_hcnt >= HCW'(H_VISIBLE + H_FRONT)) &&
                           (r_hcnt <  HCW'(H_VISIBLE + H_FRONT + H_SYNC));
    assign w_ctl.sync_v  = (r_vcnt >= VCW'(V_VISIBLE + V_FRONT)) &&
                           (r_vcnt <  VCW'(V_VISIBLE + V_FRONT + V_SYNC));

    vga_delay_line #(
        .WIDTH     ($bits(scan_ctl_t)),
        .DEPTH     (READ_LATENCY),
        .RESET_VAL ('0)
    ) u_ctl_dly (
        .clk (clock),
        .rst (reset),
        .i_d (w_ctl),
        .o_q (w_ctl_dly)
    );

    // Blanking zeroes the DAC so whatever the memory returns there never shows
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            if (w_ctl_dly.visible) begin
                r_r <= bus.colorIn[23:16];
                r_g <= bus.colorIn[15:8];
                r_b <= bus.colorIn[7:0];
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
            r_hs      <= ~w_ctl_dly.sync_h;
            r_vs      <= ~w_ctl_dly.sync_v;
            r_blank_n <= w_ctl_dly.visible;
        end
    end

    assign bus.curAddress  = r_addr;
    assign bus.frame_start = r_frame_start;
    assign bus.vga_r       = r_r;
    assign bus.vga_g       = r_g;
    assign bus.vga_b       = r_b;
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
    assign bus.vga_blank_n = r_blank_n;
endmodule
`default_nettype wire

// File: tb/tb_vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_controller
// Brief    : Self-checking bench: full 640x480 timing instance plus a reduced
//            timing instance for frame-level behaviour.
// Revision : 1.0
// ============================================================================
module tb_vga_scan_controller;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int lat;
    } tcfg_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        fs;
    } exp_t;

    localparam tcfg_t CFG_F = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam tcfg_t CFG_S = '{16, 4, 8, 4, 12, 2, 2, 3, 3};

    logic clk = 1'b0;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;
    int   cyc_f = 0;
    int   cyc_s = 0;
    int   n_vec = 0;
    int   n_err = 0;

    int   fs_t[$];
    int   vs_low, vs_falls, hs_falls, max_addr;
    logic prev_hs, prev_vs;

    vga_scan_controller_if bus_f ();
    vga_scan_controller_if bus_s ();

    vga_scan_controller #(.READ_LATENCY(CFG_F.lat)) u_dut_full (
        .clock (clk),
        .reset (rst_f),
        .bus   (bus_f)
    );

    vga_scan_controller #(
        .READ_LATENCY (CFG_S.lat),
        .H_VISIBLE (CFG_S.hv), .H_FRONT (CFG_S.hf), .H_SYNC (CFG_S.hs), .H_BACK (CFG_S.hb),
        .V_VISIBLE (CFG_S.vv), .V_FRONT (CFG_S.vf), .V_SYNC (CFG_S.vs), .V_BACK (CFG_S.vb)
    ) u_dut_small (
        .clock (clk),
        .reset (rst_s),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_f <= rst_f ? 0 : cyc_f + 1;
        cyc_s <= rst_s ? 0 : cyc_s + 1;
    end

    // Pixel address of raster cycle q, or -1 when the raster is blanked there
    function automatic int pix(int q, tcfg_t c);
        int ht, vt, x, y;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        if (q < 0) return -1;
        x = q % ht;
        y = (q / ht) % vt;
        return (x < c.hv && y < c.vv) ? y * c.hv + x : -1;
    endfunction

    function automatic exp_t model(int n, tcfg_t c);
        exp_t e;
        int ht, vt, x, y, p, px, py, a;
        logic [23:0] col;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        x = n % ht;
        y = (n / ht) % vt;
        a = pix(n, c);
        e.addr = (a < 0) ? 19'd0 : 19'(a);
        e.fs   = (x == 0 && y == c.vv);
        p = n - c.lat - 1;
        if (p < 0) begin
            col  = 24'd0;
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.bn = 1'b0;
        end else begin
            px   = p % ht;
            py   = (p / ht) % vt;
            a    = pix(p, c);
            col  = (a < 0) ? 24'd0 : 24'(a);
            e.bn = (a >= 0);
            e.hs = !(px >= c.hv + c.hf && px < c.hv + c.hf + c.hs);
            e.vs = !(py >= c.vv + c.vf && py < c.vv + c.vf + c.vs);
        end
        e.r = col[23:16];
        e.g = col[15:8];
        e.b = col[7:0];
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Memory model: echoes the fetched address lat cycles later, junk in blanking
    function automatic logic [23:0] src_color(int n, tcfg_t c);
        int a;
        a = pix(n - c.lat, c);
        return (a < 0) ? 24'hFFFFFF : 24'(a);
    endfunction

    task automatic cmp(string tag, int n, exp_t e, exp_t a);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cyc=%0d got addr=%0d rgb=%02h%02h%02h hs=%b vs=%b blank_n=%b fs=%b exp addr=%0d rgb=%02h%02h%02h hs=%b vs=%b blank_n=%b fs=%b",
                     tag, n, a.addr, a.r, a.g, a.b, a.hs, a.vs, a.bn, a.fs,
                     e.addr, e.r, e.g, e.b, e.hs, e.vs, e.bn, e.fs);
        end
    endtask

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(bit sel, int target);
        int k;
        k = 0;
        while (((sel ? cyc_s : cyc_f) != target) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_timeout: got cyc %0d expected %0d", sel ? cyc_s : cyc_f, target);
        end
    endtask

    always @(negedge clk) begin
        exp_t af, as_;
        af.addr = bus_f.curAddress; af.r = bus_f.vga_r; af.g = bus_f.vga_g; af.b = bus_f.vga_b;
        af.hs = bus_f.vga_hs; af.vs = bus_f.vga_vs; af.bn = bus_f.vga_blank_n; af.fs = bus_f.frame_start;
        as_.addr = bus_s.curAddress; as_.r = bus_s.vga_r; as_.g = bus_s.vga_g; as_.b = bus_s.vga_b;
        as_.hs = bus_s.vga_hs; as_.vs = bus_s.vga_vs; as_.bn = bus_s.vga_blank_n; as_.fs = bus_s.frame_start;
        cmp("full", cyc_f, rst_f ? reset_exp() : model(cyc_f, CFG_F), af);
        cmp("small", cyc_s, rst_s ? reset_exp() : model(cyc_s, CFG_S), as_);
        bus_f.colorIn = rst_f ? 24'hFFFFFF : src_color(cyc_f, CFG_F);
        bus_s.colorIn = rst_s ? 24'hFFFFFF : src_color(cyc_s, CFG_S);
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        rst_f = 1'b0;
        rst_s = 1'b0;
        fork
            begin : full_branch
                wait_cyc(0, 639);  chk("addr_639_0", bus_f.curAddress, 639);
                wait_cyc(0, 640);  chk("addr_hblank", bus_f.curAddress, 0);
                wait_cyc(0, 658);  chk("hs_before_sync", bus_f.vga_hs, 1);
                wait_cyc(0, 659);  chk("hs_sync_start", bus_f.vga_hs, 0);
                wait_cyc(0, 754);  chk("hs_sync_last", bus_f.vga_hs, 0);
                wait_cyc(0, 755);  chk("hs_sync_end", bus_f.vga_hs, 1);
                wait_cyc(0, 800);  chk("addr_0_1", bus_f.curAddress, 640);
                wait_cyc(0, 2405); chk("addr_5_3", bus_f.curAddress, 1925);
                wait_cyc(0, 2408);
                chk("r_5_3", bus_f.vga_r, 8'h00);
                chk("g_5_3", bus_f.vga_g, 8'h07);
                chk("b_5_3", bus_f.vga_b, 8'h85);
                chk("blank_n_5_3", bus_f.vga_blank_n, 1);
                wait_cyc(0, 3100); chk("hs_pre_reset", bus_f.vga_hs, 0);
                #2 rst_f = 1'b1;
                #1;
                chk("hs_async_reset", bus_f.vga_hs, 1);
                chk("blank_async_reset", bus_f.vga_blank_n, 0);
                chk("addr_async_reset", bus_f.curAddress, 0);
                repeat (2) @(negedge clk);
                #2 rst_f = 1'b0;
                wait_cyc(0, 3);    chk("addr_after_reset", bus_f.curAddress, 3);
                wait_cyc(0, 659);  chk("hs_after_reset", bus_f.vga_hs, 0);
            end
            begin : small_branch
                vs_low = 0; vs_falls = 0; hs_falls = 0; max_addr = 0;
                prev_hs = 1'b1; prev_vs = 1'b1;
                wait_cyc(1, 1);
                for (int k = 0; k < 4000; k++) begin
                    if (bus_s.frame_start) fs_t.push_back(cyc_s);
                    if (!bus_s.vga_vs) vs_low++;
                    if (prev_vs && !bus_s.vga_vs) vs_falls++;
                    if (prev_hs && !bus_s.vga_hs) hs_falls++;
                    if (int'(bus_s.curAddress) > max_addr) max_addr = int'(bus_s.curAddress);
                    prev_hs = bus_s.vga_hs;
                    prev_vs = bus_s.vga_vs;
                    if (cyc_s == 1824) break;
                    @(negedge clk);
                end
                chk("fs_count", fs_t.size(), 3);
                if (fs_t.size() == 3) begin
                    chk("fs_first", fs_t[0], 384);
                    chk("fs_gap1", fs_t[1] - fs_t[0], 608);
                    chk("fs_gap2", fs_t[2] - fs_t[1], 608);
                end
                chk("vs_low_cycles", vs_low, 192);
                chk("vs_pulses", vs_falls, 3);
                chk("hs_pulses", hs_falls, 57);
                chk("addr_max", max_addr, 191);
                wait_cyc(1, 2330);
                chk("s_hs_pre_reset", bus_s.vga_hs, 0);
                chk("s_vs_pre_reset", bus_s.vga_vs, 0);
                #2 rst_s = 1'b1;
                #1;
                chk("s_hs_async_reset", bus_s.vga_hs, 1);
                chk("s_vs_async_reset", bus_s.vga_vs, 1);
                repeat (2) @(negedge clk);
                #2 rst_s = 1'b0;
                wait_cyc(1, 451);  chk("s_vs_before", bus_s.vga_vs, 1);
                wait_cyc(1, 452);  chk("s_vs_restart", bus_s.vga_vs, 0);
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
